// File: rtl/hex_line_decoder_if.sv
// Byte-in / nibble-out bundle between the debug UART receiver, the hex line
// decoder and the downstream nibble-to-word packer.
interface hex_line_decoder_if #(
  parameter int ERR_W = 8
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             nib_en;
  logic [3:0]       nib;
  logic             word_done;
  logic             word_drop;
  logic             busy;
  logic [15:0]      word_cnt;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output rx_valid, rx_data,
    input  nib_en, nib, word_done, word_drop, busy, word_cnt, err_cnt
  );

  modport slave (
    input  rx_valid, rx_data,
    output nib_en, nib, word_done, word_drop, busy, word_cnt, err_cnt
  );
endinterface

// File: rtl/hex_line_decoder.sv
// Parses an ASCII debug stream into fixed-length hex words, strobing one
// nibble per digit and flagging each word as completed or dropped.
module hex_line_decoder #(
  parameter int DIGITS = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  hex_line_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

  typedef enum logic [1:0] {IDLE, DIGIT, COMMENT, BAD} state_t;
  typedef enum logic [2:0] {C_HEX, C_WS, C_SEP, C_CMT, C_OTH} cls_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  cls_t             cls;
  logic [3:0]       val;
  logic             is_lf;

  function automatic cls_t classify(input logic [7:0] c);
    if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66) ||
        (c >= 8'h41 && c <= 8'h46))
      return C_HEX;
    else if (c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A)
      return C_WS;
    else if (c == 8'h5F)
      return C_SEP;
    else if (c == 8'h23)
      return C_CMT;
    else
      return C_OTH;
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [7:0] t;
    if (c <= 8'h39)      t = c - 8'h30;
    else if (c >= 8'h61) t = c - 8'h57;
    else                 t = c - 8'h37;
    return t[3:0];
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cls   = classify(bus.rx_data);
  assign val   = hex_val(bus.rx_data);
  assign is_lf = (bus.rx_data == 8'h0A);

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.nib_en    <= 1'b0;
      bus.nib       <= '0;
      bus.word_done <= 1'b0;
      bus.word_drop <= 1'b0;
      bus.word_cnt  <= '0;
      bus.err_cnt   <= '0;
    end else begin
      bus.nib_en    <= 1'b0;
      bus.word_done <= 1'b0;
      bus.word_drop <= 1'b0;
      if (bus.rx_valid) begin
        case (state)
          IDLE: begin
            case (cls)
              C_HEX: begin
                bus.nib_en <= 1'b1;
                bus.nib    <= val;
                cnt        <= CNT_W'(1);
                state      <= DIGIT;
              end
              C_CMT: state <= COMMENT;
              // No nibble has reached the packer yet, so nothing to clear.
              C_OTH: begin
                bus.err_cnt <= sat_inc(bus.err_cnt);
                state       <= BAD;
              end
              default: ;
            endcase
          end
          DIGIT: begin
            case (cls)
              C_HEX: begin
                if (cnt < CNT_FULL) begin
                  bus.nib_en <= 1'b1;
                  bus.nib    <= val;
                  cnt        <= cnt + 1'b1;
                end else begin
                  bus.word_drop <= 1'b1;
                  bus.err_cnt   <= sat_inc(bus.err_cnt);
                  cnt           <= '0;
                  state         <= BAD;
                end
              end
              C_WS, C_CMT: begin
                if (cnt == CNT_FULL) begin
                  bus.word_done <= 1'b1;
                  bus.word_cnt  <= bus.word_cnt + 1'b1;
                end else begin
                  bus.word_drop <= 1'b1;
                  bus.err_cnt   <= sat_inc(bus.err_cnt);
                end
                cnt   <= '0;
                state <= (cls == C_CMT) ? COMMENT : IDLE;
              end
              C_OTH: begin
                bus.word_drop <= 1'b1;
                bus.err_cnt   <= sat_inc(bus.err_cnt);
                cnt           <= '0;
                state         <= BAD;
              end
              default: ;
            endcase
          end
          COMMENT, BAD: begin
            if (is_lf) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
